// File: rtl/vga_pkg.sv
// Shared VGA constants and types used by the sync generator, pattern blocks and
// the bouncing-box overlay.
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int COORD_W          = 10;
  localparam int COLOR_W          = 3;
  localparam int ARITH_W          = COORD_W + 1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Colour index cycles 1..7; 0 would render the box black and is skipped.
  function automatic color_t next_color_idx(input color_t idx);
    if (idx == 3'd7) begin
      return 3'd1;
    end else begin
      return idx + 3'd1;
    end
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of box motion: position clamped to [0, MAX], direction bit, and a
// bounce flag raised combinationally on the step that hits either wall.
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter int MAX  = 608,
  parameter int STEP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_en,
  output logic [COORD_W-1:0] pos,
  output logic               bounce
);

  localparam logic [ARITH_W-1:0] MAX_A  = ARITH_W'(MAX);
  localparam logic [ARITH_W-1:0] STEP_A = ARITH_W'(STEP);

  logic [COORD_W-1:0] pos_r;
  logic               dir_r;
  logic [ARITH_W-1:0] pos_ext_s;
  logic [ARITH_W-1:0] pos_inc_s;
  logic [ARITH_W-1:0] pos_dec_s;
  logic [COORD_W-1:0] pos_nxt_s;
  logic               dir_nxt_s;
  logic               bounce_s;

  // Next position/direction; 11-bit compares keep the clamp free of wrap-around.
  always_comb begin
    pos_ext_s = {1'b0, pos_r};
    pos_inc_s = pos_ext_s + STEP_A;
    pos_dec_s = pos_ext_s - STEP_A;
    pos_nxt_s = pos_r;
    dir_nxt_s = dir_r;
    bounce_s  = 1'b0;
    if (step_en) begin
      if (!dir_r) begin
        if (pos_inc_s >= MAX_A) begin
          pos_nxt_s = MAX_A[COORD_W-1:0];
          dir_nxt_s = 1'b1;
          bounce_s  = 1'b1;
        end else begin
          pos_nxt_s = pos_inc_s[COORD_W-1:0];
        end
      end else begin
        if (pos_ext_s <= STEP_A) begin
          pos_nxt_s = {COORD_W{1'b0}};
          dir_nxt_s = 1'b0;
          bounce_s  = 1'b1;
        end else begin
          pos_nxt_s = pos_dec_s[COORD_W-1:0];
        end
      end
    end else begin
      pos_nxt_s = pos_r;
      dir_nxt_s = dir_r;
      bounce_s  = 1'b0;
    end
  end

  // Motion state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_r <= {COORD_W{1'b0}};
      dir_r <= 1'b0;
    end else begin
      pos_r <= pos_nxt_s;
      dir_r <= dir_nxt_s;
    end
  end

  assign pos    = pos_r;
  assign bounce = bounce_s;

endmodule

// File: rtl/vga_bounce_box.sv
// Bouncing coloured box overlay: moves once per frame on the vsync falling edge
// and paints the box with a registered, one-clock-latency colour output.
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  input  logic               i_activeArea,
  input  logic               i_vs,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic [7:0]         o_bounceCount
);

  localparam int                 MAX_X = H_ACTIVE - BOX_SIZE;
  localparam int                 MAX_Y = V_ACTIVE - BOX_SIZE;
  localparam logic [ARITH_W-1:0] BOX_A = ARITH_W'(BOX_SIZE);

  logic               prev_vs_r;
  logic               armed_r;
  logic               tick_s;
  logic               step_en_s;
  logic [COORD_W-1:0] x_pos_s;
  logic [COORD_W-1:0] y_pos_s;
  logic               bounce_x_s;
  logic               bounce_y_s;
  logic               any_bounce_s;
  color_t             color_idx_r;
  logic [7:0]         bounce_count_r;
  logic               inside_s;
  logic [COLOR_W-1:0] red_nxt_s;
  logic [COLOR_W-1:0] green_nxt_s;
  logic [COLOR_W-1:0] blue_nxt_s;
  logic [COLOR_W-1:0] red_r;
  logic [COLOR_W-1:0] green_r;
  logic [COLOR_W-1:0] blue_r;

  // armed_r masks the first post-reset cycle so a low vsync there is not an edge.
  assign tick_s       = armed_r & prev_vs_r & ~i_vs;
  assign step_en_s    = tick_s & i_enable;
  assign any_bounce_s = bounce_x_s | bounce_y_s;

  // Vsync edge detector state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prev_vs_r <= 1'b1;
      armed_r   <= 1'b0;
    end else begin
      prev_vs_r <= i_vs;
      armed_r   <= 1'b1;
    end
  end

  vga_bounce_axis #(.MAX(MAX_X), .STEP(STEP)) u_axis_x (
    .clk     (i_clk),
    .reset   (i_reset),
    .step_en (step_en_s),
    .pos     (x_pos_s),
    .bounce  (bounce_x_s)
  );

  vga_bounce_axis #(.MAX(MAX_Y), .STEP(STEP)) u_axis_y (
    .clk     (i_clk),
    .reset   (i_reset),
    .step_en (step_en_s),
    .pos     (y_pos_s),
    .bounce  (bounce_y_s)
  );

  // Colour index and bounce counter; a corner hit advances them once.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      color_idx_r    <= 3'd1;
      bounce_count_r <= 8'd0;
    end else if (any_bounce_s) begin
      color_idx_r    <= next_color_idx(color_idx_r);
      bounce_count_r <= bounce_count_r + 8'd1;
    end else begin
      color_idx_r    <= color_idx_r;
      bounce_count_r <= bounce_count_r;
    end
  end

  assign inside_s = ({1'b0, i_px} >= {1'b0, x_pos_s}) &&
                    ({1'b0, i_px} <  ({1'b0, x_pos_s} + BOX_A)) &&
                    ({1'b0, i_py} >= {1'b0, y_pos_s}) &&
                    ({1'b0, i_py} <  ({1'b0, y_pos_s} + BOX_A));

  // Pixel colour; uses the pre-update position on a tick cycle so frames never tear.
  always_comb begin
    if (i_activeArea && inside_s) begin
      red_nxt_s   = {COLOR_W{color_idx_r[0]}};
      green_nxt_s = {COLOR_W{color_idx_r[1]}};
      blue_nxt_s  = {COLOR_W{color_idx_r[2]}};
    end else begin
      red_nxt_s   = {COLOR_W{1'b0}};
      green_nxt_s = {COLOR_W{1'b0}};
      blue_nxt_s  = {COLOR_W{1'b0}};
    end
  end

  // Output colour register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      red_r   <= {COLOR_W{1'b0}};
      green_r <= {COLOR_W{1'b0}};
      blue_r  <= {COLOR_W{1'b0}};
    end else begin
      red_r   <= red_nxt_s;
      green_r <= green_nxt_s;
      blue_r  <= blue_nxt_s;
    end
  end

  assign o_red         = red_r;
  assign o_green       = green_r;
  assign o_blue        = blue_r;
  assign o_bounceCount = bounce_count_r;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Scoreboard bench for vga_bounce_box: a default-size instance plus a square
// 480x480 instance whose box reaches a corner on a single frame.
module tb_vga_bounce_box;

  localparam int STEP = 2;
  localparam int BOX  = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       active;
  logic       vs;
  logic [9:0] px;
  logic [9:0] py;
  logic [2:0] r0, g0, b0, r1, g1, b1;
  logic [7:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  vga_bounce_box dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_px(px), .i_py(py),
    .i_activeArea(active), .i_vs(vs), .o_red(r0), .o_green(g0), .o_blue(b0),
    .o_bounceCount(cnt0)
  );

  vga_bounce_box #(.H_ACTIVE(480), .V_ACTIVE(480), .BOX_SIZE(32), .STEP(2)) dut_sq (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_px(px), .i_py(py),
    .i_activeArea(active), .i_vs(vs), .o_red(r1), .o_green(g1), .o_blue(b1),
    .o_bounceCount(cnt1)
  );

  // Reference model state, one slot per instance.
  int mx[2], my[2], mdx[2], mdy[2], midx[2], mcnt[2];
  int maxx[2] = '{608, 448};
  int maxy[2] = '{448, 448};

  typedef struct {
    string tag;
    int    inst;
    int    exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; midx[i] = 1; mcnt[i] = 0;
    end
  endtask

  task automatic axis_step(input int p_in, input int d_in, input int lim,
                           output int p, output int d, output bit b);
    p = p_in; d = d_in; b = 1'b0;
    if (d_in == 0) begin
      if (p_in + STEP >= lim) begin p = lim; d = 1; b = 1'b1; end
      else p = p_in + STEP;
    end else begin
      if (p_in <= STEP) begin p = 0; d = 0; b = 1'b1; end
      else p = p_in - STEP;
    end
  endtask

  task automatic model_tick();
    int  p, d;
    bit  bx, by;
    for (int i = 0; i < 2; i++) begin
      if (enable) begin
        axis_step(mx[i], mdx[i], maxx[i], p, d, bx);
        mx[i] = p; mdx[i] = d;
        axis_step(my[i], mdy[i], maxy[i], p, d, by);
        my[i] = p; mdy[i] = d;
        if (bx || by) begin
          midx[i] = (midx[i] == 7) ? 1 : midx[i] + 1;
          mcnt[i] = (mcnt[i] + 1) % 256;
        end
      end
    end
  endtask

  function automatic int exp_color(input int i, input int x, input int y, input bit a);
    logic [2:0] ix;
    ix = midx[i][2:0];
    if (a && x >= mx[i] && x < mx[i] + BOX && y >= my[i] && y < my[i] + BOX)
      return int'({{3{ix[0]}}, {3{ix[1]}}, {3{ix[2]}}});
    return 0;
  endfunction

  // Drive one pixel, queue both instances' expectations, compare next cycle.
  task automatic probe(input string tag, input int x, input int y, input bit a);
    sb_t e;
    @(negedge clk);
    px = x[9:0]; py = y[9:0]; active = a;
    for (int i = 0; i < 2; i++) sb_q.push_back('{tag, i, exp_color(i, x, y, a)});
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.inst == 0) check_eq({e.tag, "_rgb0"}, {23'd0, r0, g0, b0}, e.exp);
      else             check_eq({e.tag, "_rgb1"}, {23'd0, r1, g1, b1}, e.exp);
    end
  endtask

  task automatic probe_box(input string tag, input int i);
    int x, y;
    x = mx[i]; y = my[i];
    probe({tag, "_tl"}, x, y, 1'b1);
    probe({tag, "_br"}, x + BOX - 1, y + BOX - 1, 1'b1);
    probe({tag, "_right"}, x + BOX, y, 1'b1);
    probe({tag, "_below"}, x, y + BOX, 1'b1);
    if (x > 0) probe({tag, "_left"}, x - 1, y, 1'b1);
    if (y > 0) probe({tag, "_above"}, x, y - 1, 1'b1);
  endtask

  task automatic frame_tick();
    @(negedge clk);
    vs = 1'b1; active = 1'b0;
    @(negedge clk);
    vs = 1'b0;
    model_tick();
    @(negedge clk);
    vs = 1'b1;
    check_eq("cnt0", {24'd0, cnt0}, mcnt[0]);
    check_eq("cnt1", {24'd0, cnt1}, mcnt[1]);
  endtask

  initial begin
    int guard;
    reset = 1'b1; enable = 1'b1; active = 1'b0; vs = 1'b1; px = 10'd0; py = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_cnt0", {24'd0, cnt0}, 0);
    check_eq("rst_rgb0", {23'd0, r0, g0, b0}, 0);
    reset = 1'b0;

    probe("pix00", 0, 0, 1'b1);
    check_eq("pix00_red", 448, exp_color(0, 0, 0, 1'b1));

    repeat (10) frame_tick();
    probe_box("t10", 0);

    guard = 0;
    while (!(mx[0] == 606 && mdx[0] == 0) && guard < 400) begin
      frame_tick();
      guard++;
    end
    check_eq("reach606_guard", guard < 400, 1);
    probe_box("x606", 0);
    probe_box("sq", 1);

    frame_tick();
    probe_box("x608", 0);
    probe("x608_edge", 607 + BOX, my[0], 1'b1);
    frame_tick();
    probe_box("x606b", 0);

    enable = 1'b0;
    repeat (5) frame_tick();
    probe_box("hold", 0);
    probe_box("hold_sq", 1);
    probe("inactive", mx[0] + 1, my[0] + 1, 1'b0);

    // Reset lands on the same edge as a vsync fall; it must win.
    enable = 1'b1;
    @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0; reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rot_cnt0", {24'd0, cnt0}, mcnt[0]);
    check_eq("rot_cnt1", {24'd0, cnt1}, mcnt[1]);
    probe("rot_pix00", 0, 0, 1'b1);
    probe("rot_pix32", BOX, 0, 1'b1);
    probe("rot_pix2", 2, 2, 1'b1);

    frame_tick();
    probe_box("after_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
